// File: rtl/exhaustive_sweep_engine_pkg.sv
// -----------------------------------------------------------------------------
// exhaustive_sweep_engine_pkg
//   Shared types and helpers for the exhaustive sweep engine.
//   - state_e          : sweep controller states
//   - DEFAULT_SIG_POLY : default MISR feedback polynomial
//   - bin2gray         : binary to reflected Gray code (up to 16 bits)
//   - fold_resp        : XOR-fold a response (up to 32 bits) into sig_w bits
// -----------------------------------------------------------------------------
package exhaustive_sweep_engine_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [15:0] DEFAULT_SIG_POLY = 16'h1021;

    // Narrower patterns are zero-extended by the caller; the top bit of a
    // zero-extended value XORs with 0, so truncating the result stays correct.
    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bit i of the response lands on signature bit (i mod sig_w). Bits above
    // the real response width are zero after extension and fold in harmlessly.
    function automatic logic [31:0] fold_resp(input logic [31:0] resp, input int sig_w);
        logic [31:0] acc;
        logic [4:0]  idx;
        acc = 32'd0;
        for (int i = 0; i < 32; i++) begin
            idx      = 5'(i % sig_w);
            acc[idx] = acc[idx] ^ resp[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/exhaustive_sweep_engine_if.sv
// -----------------------------------------------------------------------------
// exhaustive_sweep_engine_if
//   Record stream from the sweep engine to a logger (valid/ready).
//   rec_valid : record available          (engine -> logger)
//   rec_ready : logger accepts the record  (logger -> engine)
//   rec_pat   : pattern of the record      (engine -> logger)
//   rec_resp  : response captured for it   (engine -> logger)
// -----------------------------------------------------------------------------
interface exhaustive_sweep_engine_if #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 1
) ();
    logic             rec_valid;
    logic             rec_ready;
    logic [IN_W-1:0]  rec_pat;
    logic [OUT_W-1:0] rec_resp;

    modport master (output rec_valid, output rec_pat, output rec_resp, input rec_ready);
    modport slave  (input rec_valid, input rec_pat, input rec_resp, output rec_ready);
endinterface

// File: rtl/exhaustive_sweep_engine_misr.sv
// -----------------------------------------------------------------------------
// exhaustive_sweep_engine_misr
//   Multiple-input signature register compressing every handshaken response.
//   Built only when SWEEP_MISR_EN is defined.
//   CK     : clock, rising edge
//   reset  : asynchronous active-high reset
//   clear  : synchronous clear (sweep start accepted)
//   update : shift in one response (record handshake)
//   resp   : response to fold into the signature
//   sig    : current signature
// -----------------------------------------------------------------------------
module exhaustive_sweep_engine_misr
    import exhaustive_sweep_engine_pkg::*;
#(
    parameter int               OUT_W    = 1,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEFAULT_SIG_POLY)
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             clear,
    input  logic             update,
    input  logic [OUT_W-1:0] resp,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_r;
    logic [SIG_W-1:0] fold_s;
    logic [SIG_W-1:0] fb_s;
    logic [SIG_W-1:0] sig_next_s;

    // Next signature: shift left, apply polynomial on carry-out, add folded input.
    always_comb begin
        fold_s = SIG_W'(fold_resp(32'(resp), SIG_W));
        if (sig_r[SIG_W-1]) begin
            fb_s = SIG_POLY;
        end else begin
            fb_s = {SIG_W{1'b0}};
        end
        sig_next_s = {sig_r[SIG_W-2:0], 1'b0} ^ fb_s ^ fold_s;
    end

    // Signature register; start clear has priority over an update.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            sig_r <= {SIG_W{1'b0}};
        end else if (clear) begin
            sig_r <= {SIG_W{1'b0}};
        end else if (update) begin
            sig_r <= sig_next_s;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/exhaustive_sweep_engine.sv
// -----------------------------------------------------------------------------
// exhaustive_sweep_engine
//   Drives every IN_W-bit pattern (binary or Gray order) onto a DUT, holds it
//   SETTLE_CYC cycles, captures the response and streams (pattern, response)
//   records to a logger over a valid/ready interface.
//   Optional feature macro: SWEEP_MISR_EN adds sig_o and a response MISR.
// Ports
//   CK        : clock, rising edge
//   reset     : asynchronous active-high reset
//   start     : begin a sweep (honoured in IDLE or DONE only)
//   mode_gray : 0 binary order, 1 Gray order; sampled with start
//   pat_o     : pattern driven to the DUT inputs
//   resp_i    : DUT response
//   rec       : record stream (master side)
//   busy      : high while settling or emitting
//   done      : high after the last record until the next start
//   sig_o     : response signature (SWEEP_MISR_EN only)
// -----------------------------------------------------------------------------
module exhaustive_sweep_engine
    import exhaustive_sweep_engine_pkg::*;
#(
    parameter int               IN_W       = 5,
    parameter int               OUT_W      = 1,
    parameter int               SETTLE_CYC = 1,
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] SIG_POLY   = SIG_W'(DEFAULT_SIG_POLY)
) (
    input  logic                      CK,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      mode_gray,
    output logic [IN_W-1:0]           pat_o,
    input  logic [OUT_W-1:0]          resp_i,
    exhaustive_sweep_engine_if.master rec,
    output logic                      busy,
    output logic                      done
`ifdef SWEEP_MISR_EN
    ,
    output logic [SIG_W-1:0]          sig_o
`endif
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETTLE = SETTLE;
    localparam logic [1:0] S_EMIT   = EMIT;
    localparam logic [1:0] S_DONE   = DONE;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [1:0]       state_r;
    logic [IN_W-1:0]  cnt_r;
    logic [IN_W-1:0]  pat_r;
    logic             gray_r;
    logic [SET_W-1:0] settle_r;
    logic             rec_valid_r;
    logic [IN_W-1:0]  rec_pat_r;
    logic [OUT_W-1:0] rec_resp_r;
    logic             busy_r;
    logic             done_r;

    logic             start_acc_s;
    logic             settle_end_s;
    logic             hs_s;
    logic             last_s;
    logic [IN_W-1:0]  cnt_next_s;
    logic [IN_W-1:0]  pat_next_s;

    // Control decodes; start is only honoured from the idle-like states.
    always_comb begin
        start_acc_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE));
        settle_end_s = (state_r == S_SETTLE) && (settle_r == SET_W'(SETTLE_CYC - 1));
        hs_s         = (state_r == S_EMIT) && rec_valid_r && rec.rec_ready;
        last_s       = (cnt_r == {IN_W{1'b1}});
    end

    // Next pattern, precomputed so pat_o comes straight from a register.
    always_comb begin
        cnt_next_s = cnt_r + IN_W'(1);
        if (gray_r) begin
            pat_next_s = IN_W'(bin2gray(16'(cnt_next_s)));
        end else begin
            pat_next_s = cnt_next_s;
        end
    end

    // Sweep controller and all registered outputs.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= {IN_W{1'b0}};
            pat_r       <= {IN_W{1'b0}};
            gray_r      <= 1'b0;
            settle_r    <= {SET_W{1'b0}};
            rec_valid_r <= 1'b0;
            rec_pat_r   <= {IN_W{1'b0}};
            rec_resp_r  <= {OUT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start_acc_s) begin
                        state_r  <= S_SETTLE;
                        cnt_r    <= {IN_W{1'b0}};
                        pat_r    <= {IN_W{1'b0}};  // pattern 0 is 0 in both orders
                        gray_r   <= mode_gray;
                        settle_r <= {SET_W{1'b0}};
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (settle_end_s) begin
                        rec_pat_r   <= pat_r;
                        rec_resp_r  <= resp_i;
                        rec_valid_r <= 1'b1;
                        state_r     <= S_EMIT;
                    end else begin
                        settle_r <= settle_r + SET_W'(1);
                    end
                end
                S_EMIT: begin
                    if (hs_s) begin
                        rec_valid_r <= 1'b0;
                        settle_r    <= {SET_W{1'b0}};
                        if (last_s) begin
                            // No wrap: the sweep ends on the all-ones count.
                            state_r <= S_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            cnt_r   <= cnt_next_s;
                            pat_r   <= pat_next_s;
                            state_r <= S_SETTLE;
                        end
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    rec_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign pat_o         = pat_r;
    assign rec.rec_valid = rec_valid_r;
    assign rec.rec_pat   = rec_pat_r;
    assign rec.rec_resp  = rec_resp_r;
    assign busy          = busy_r;
    assign done          = done_r;

`ifdef SWEEP_MISR_EN
    exhaustive_sweep_engine_misr #(
        .OUT_W    (OUT_W),
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr (
        .CK     (CK),
        .reset  (reset),
        .clear  (start_acc_s),
        .update (hs_s),
        .resp   (rec_resp_r),
        .sig    (sig_o)
    );
`else
    // Signature parameters only matter when the MISR is built.
    logic sig_cfg_unused_s;
    assign sig_cfg_unused_s = ^SIG_POLY;
`endif

endmodule

// File: tb/tb_exhaustive_sweep_engine.sv
// Directed bench for exhaustive_sweep_engine (IN_W=5, OUT_W=1, SETTLE_CYC=1).
module tb_exhaustive_sweep_engine;
    localparam int IN_W  = 5;
    localparam int OUT_W = 1;

    logic CK = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic mode_gray = 1'b0;
    logic [IN_W-1:0]  pat_o;
    logic [OUT_W-1:0] resp_i;
    logic busy;
    logic done;
`ifdef SWEEP_MISR_EN
    logic [15:0] sig_o;
`endif

    int resp_sel = 0;   // 0: parity of pat_o, 1: zero, 2: pat_o[0]
    int checks = 0;
    int errors = 0;

    logic [IN_W-1:0]  q_pat[$];
    logic [OUT_W-1:0] q_resp[$];

    exhaustive_sweep_engine_if #(.IN_W(IN_W), .OUT_W(OUT_W)) rec_bus ();

    exhaustive_sweep_engine #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYC(1)
    ) dut (
        .CK(CK), .reset(reset), .start(start), .mode_gray(mode_gray),
        .pat_o(pat_o), .resp_i(resp_i), .rec(rec_bus), .busy(busy), .done(done)
`ifdef SWEEP_MISR_EN
        , .sig_o(sig_o)
`endif
    );

    always #5 CK = ~CK;

    always_comb begin
        if (resp_sel == 1) resp_i = 1'b0;
        else if (resp_sel == 2) resp_i = pat_o[0];
        else resp_i = ^pat_o;
    end

    // Logger: record every handshake.
    always @(posedge CK) begin
        if (rec_bus.rec_valid && rec_bus.rec_ready) begin
            q_pat.push_back(rec_bus.rec_pat);
            q_resp.push_back(rec_bus.rec_resp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Called from just after an edge: start is seen at the next edge.
    task automatic start_sweep(input logic g);
        start = 1'b1;
        mode_gray = g;
        @(posedge CK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge CK); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rec_bus.rec_ready = 1'b1;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({pat_o, rec_bus.rec_valid, rec_bus.rec_pat, rec_bus.rec_resp, busy, done} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got pat=%0d valid=%0d rpat=%0d rresp=%0d busy=%0d done=%0d, want all 0",
                     pat_o, rec_bus.rec_valid, rec_bus.rec_pat, rec_bus.rec_resp, busy, done);
        end
        repeat (2) @(posedge CK);
        @(negedge CK) reset = 1'b0;
        @(posedge CK); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0d done=%0d, want 0 0", busy, done);
        end
    endtask

    task automatic test_binary();
        int n;
        q_pat.delete(); q_resp.delete();
        resp_sel = 0;
        start_sweep(1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || pat_o !== 5'd0) begin
            errors++;
            $display("FAIL bin_start: busy=%0d done=%0d pat=%0d, want 1 0 0", busy, done, pat_o);
        end
        wait_done(200, n);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL bin_done_latency: got %0d edges, want 64", n);
        end
        checks++;
        if (busy !== 1'b0 || rec_bus.rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL bin_done_state: busy=%0d valid=%0d, want 0 0", busy, rec_bus.rec_valid);
        end
        checks++;
        if (q_pat.size() !== 32) begin
            errors++;
            $display("FAIL bin_count: got %0d records, want 32", q_pat.size());
        end
        for (int i = 0; i < 32 && i < q_pat.size(); i++) begin
            logic [4:0] e;
            e = 5'(i);
            checks++;
            if (q_pat[i] !== e || q_resp[i] !== ^e) begin
                errors++;
                $display("FAIL bin_rec[%0d]: got pat=%0d resp=%0d, want pat=%0d resp=%0d",
                         i, q_pat[i], q_resp[i], e, ^e);
            end
        end
    endtask

    task automatic test_gray();
        int n;
        q_pat.delete(); q_resp.delete();
        start_sweep(1'b1);
        wait_done(200, n);
        checks++;
        if (n !== 64 || q_pat.size() !== 32) begin
            errors++;
            $display("FAIL gray_sweep: got %0d edges %0d records, want 64 32", n, q_pat.size());
        end
        for (int i = 0; i < 32 && i < q_pat.size(); i++) begin
            logic [4:0] b;
            logic [4:0] g;
            b = 5'(i);
            g = b ^ (b >> 1);
            checks++;
            if (q_pat[i] !== g || q_resp[i] !== ^g) begin
                errors++;
                $display("FAIL gray_rec[%0d]: got pat=%0d resp=%0d, want pat=%0d resp=%0d",
                         i, q_pat[i], q_resp[i], g, ^g);
            end
            if (i > 0) begin
                checks++;
                if ($countones(q_pat[i] ^ q_pat[i-1]) != 1) begin
                    errors++;
                    $display("FAIL gray_step[%0d]: %0d -> %0d, want exactly 1 bit change",
                             i, q_pat[i-1], q_pat[i]);
                end
            end
        end
        checks++;
        if (q_pat.size() == 32 && q_pat[31] !== 5'b10000) begin
            errors++;
            $display("FAIL gray_last: got %0d, want 16", q_pat[31]);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int k;
        q_pat.delete(); q_resp.delete();
        start_sweep(1'b0);
        k = 0;
        while (!(pat_o === 5'd3 && rec_bus.rec_valid === 1'b0) && k < 100) begin
            @(posedge CK); #1;
            k++;
        end
        checks++;
        if (k >= 100) begin
            errors++;
            $display("FAIL bp_find: pattern 3 settle not seen, want seen within 100 edges");
        end
        rec_bus.rec_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge CK); #1;
            checks++;
            if (rec_bus.rec_valid !== 1'b1 || rec_bus.rec_pat !== 5'd3 || pat_o !== 5'd3) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%0d rpat=%0d pat=%0d, want 1 3 3",
                         c, rec_bus.rec_valid, rec_bus.rec_pat, pat_o);
            end
        end
        rec_bus.rec_ready = 1'b1;
        wait_done(200, n);
        checks++;
        if (done !== 1'b1 || q_pat.size() !== 32) begin
            errors++;
            $display("FAIL bp_count: done=%0d records=%0d, want 1 32", done, q_pat.size());
        end
        for (int i = 0; i < 32 && i < q_pat.size(); i++) begin
            checks++;
            if (q_pat[i] !== 5'(i)) begin
                errors++;
                $display("FAIL bp_rec[%0d]: got %0d, want %0d", i, q_pat[i], i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int k;
        start_sweep(1'b0);
        k = 0;
        while (pat_o !== 5'd10 && k < 100) begin
            @(posedge CK); #1;
            k++;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (k >= 100 || {pat_o, rec_bus.rec_valid, rec_bus.rec_pat, rec_bus.rec_resp, busy, done} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid: k=%0d pat=%0d valid=%0d rpat=%0d rresp=%0d busy=%0d done=%0d, want all 0",
                     k, pat_o, rec_bus.rec_valid, rec_bus.rec_pat, rec_bus.rec_resp, busy, done);
        end
        #1 reset = 1'b0;
        @(posedge CK); #1;
        checks++;
        if (busy !== 1'b0 || pat_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy=%0d pat=%0d, want 0 0", busy, pat_o);
        end
        q_pat.delete(); q_resp.delete();
        start_sweep(1'b0);
        wait_done(200, n);
        checks++;
        if (n !== 64 || q_pat.size() !== 32 || (q_pat.size() > 0 && q_pat[0] !== 5'd0)) begin
            errors++;
            $display("FAIL reset_mid_resweep: edges=%0d records=%0d, want 64 32 from 0", n, q_pat.size());
        end
    endtask

    task automatic test_start_handling();
        int n;
        int k;
        q_pat.delete(); q_resp.delete();
        start_sweep(1'b0);
        repeat (20) begin @(posedge CK); #1; end
        start = 1'b1; mode_gray = 1'b1;
        @(posedge CK); #1;
        start = 1'b0; mode_gray = 1'b0;
        wait_done(200, n);
        checks++;
        if (n + 21 !== 64 || q_pat.size() !== 32) begin
            errors++;
            $display("FAIL busy_start_ignored: edges=%0d records=%0d, want 64 32", n + 21, q_pat.size());
        end
        for (int i = 0; i < 32 && i < q_pat.size(); i++) begin
            checks++;
            if (q_pat[i] !== 5'(i)) begin
                errors++;
                $display("FAIL busy_start_rec[%0d]: got %0d, want %0d", i, q_pat[i], i);
            end
        end
        q_pat.delete(); q_resp.delete();
        start_sweep(1'b1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || pat_o !== 5'd0) begin
            errors++;
            $display("FAIL restart: done=%0d busy=%0d pat=%0d, want 0 1 0", done, busy, pat_o);
        end
        k = 0;
        while (!(pat_o === 5'd16 && rec_bus.rec_valid === 1'b1) && k < 200) begin
            @(posedge CK); #1;
            k++;
        end
        start = 1'b1;
        @(posedge CK); #1;
        start = 1'b0;
        checks++;
        if (k >= 200 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_vs_final: k=%0d done=%0d busy=%0d, want done 1 busy 0", k, done, busy);
        end
        repeat (3) begin @(posedge CK); #1; end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_not_retained: done=%0d busy=%0d, want 1 0", done, busy);
        end
        checks++;
        if (q_pat.size() !== 32 || q_pat[2] !== 5'd3 || q_pat[31] !== 5'd16) begin
            errors++;
            $display("FAIL restart_gray: records=%0d, want 32 in Gray order", q_pat.size());
        end
    endtask

`ifdef SWEEP_MISR_EN
    task automatic test_misr();
        int n;
        logic [15:0] m;
        logic fb;
        resp_sel = 2;
        start_sweep(1'b0);
        wait_done(200, n);
        m = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            fb = m[15];
            m = {m[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000) ^ 16'(i & 1);
        end
        checks++;
        if (done !== 1'b1 || sig_o !== m) begin
            errors++;
            $display("FAIL misr_lsb: got %h, want %h", sig_o, m);
        end
        resp_sel = 1;
        start_sweep(1'b0);
        wait_done(200, n);
        checks++;
        if (done !== 1'b1 || sig_o !== 16'h0000) begin
            errors++;
            $display("FAIL misr_zero: got %h, want 0000", sig_o);
        end
        resp_sel = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_binary();
        test_gray();
        test_backpressure();
        test_reset_mid();
        test_start_handling();
`ifdef SWEEP_MISR_EN
        test_misr();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
